adpll_tx_serializer: RTL and testbench

// Upstream TX data stage for adpll_ctr0. Buffers payload bytes from the baseband in a small FIFO.

---
 rtl/adpll_tx_serializer.sv | 181 ++++++++++++++++++
 tb/tb_adpll_tx_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_tx_serializer.sv
// adpll_tx_serializer: buffers baseband payload bytes in a small FIFO and serialises them
// onto data_mod, one bit per SYM_CYCLES clk, while adpll_ctr0 is locked in TX mode.
// Latency: a push is popped 1 clk later at the earliest, and the first bit shows 1 clk after the pop.
// Backpressure: byte_ready low when idle or FIFO full; a pop never frees a slot in the same cycle.
// Ports:
//   clk, rst_n                      clock and synchronous active-low reset
//   en, adpll_mode, channel_lock    arming inputs (armed = en & TX mode & lock)
//   byte_data/byte_valid/byte_ready payload byte handshake
//   data_mod, sym_strobe            registered modulation bit and its 1-clk update pulse
//   busy, underrun, fifo_level      status: shifting, byte ended with empty FIFO, occupancy
module adpll_tx_serializer #(
    parameter int SYM_CYCLES = 32,
    parameter int FIFO_DEPTH = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    adpll_mode,
    input  logic                          channel_lock,
    input  logic [7:0]                    byte_data,
    input  logic                          byte_valid,
    output logic                          byte_ready,
    output logic                          data_mod,
    output logic                          sym_strobe,
    output logic                          busy,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int SCW = $clog2(SYM_CYCLES);
    localparam logic [1:0] MODE_TX = 2'd3;

    typedef enum logic [1:0] {IDLE, READY, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [SCW-1:0]   sym_cnt_q, sym_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             data_mod_q, data_mod_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;
    logic [7:0]       mem_q [FIFO_DEPTH];

    logic             armed;
    logic             push;
    logic             pop;
    logic             mem_we;
    logic [7:0]       head;

    assign armed      = en & (adpll_mode == MODE_TX) & channel_lock;
    assign byte_ready = (state_q != IDLE) && (level_q < LW'(FIFO_DEPTH));
    assign push       = byte_valid & byte_ready;
    assign head       = mem_q[rd_ptr_q];

    assign data_mod   = data_mod_q;
    assign sym_strobe = strobe_q;
    assign underrun   = underrun_q;
    assign busy       = (state_q == SHIFT);
    assign fifo_level = level_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        shreg_d    = shreg_q;
        sym_cnt_d  = sym_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_mod_d = data_mod_q;
        strobe_d   = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        mem_we     = 1'b0;

        if (!armed) begin
            // Disarm aborts everything immediately, including a byte in flight.
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            shreg_d    = '0;
            sym_cnt_d  = '0;
            bit_cnt_d  = '0;
            data_mod_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_d = READY;
                READY: begin
                    data_mod_d = 1'b0;
                    sym_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sym_cnt_q == SCW'(SYM_CYCLES - 1)) begin
                        sym_cnt_d = '0;
                        if (bit_cnt_q != 3'd7) begin
                            bit_cnt_d  = bit_cnt_q + 3'd1;
                            data_mod_d = LSB_FIRST ? shreg_q[0] : shreg_q[7];
                            shreg_d    = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
                            strobe_d   = 1'b1;
                        end else if (level_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d    = READY;
                            underrun_d = 1'b1;
                            data_mod_d = 1'b0;
                            bit_cnt_d  = '0;
                            shreg_d    = '0;
                        end
                    end else begin
                        sym_cnt_d = sym_cnt_q + SCW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            // A pop loads the head byte: its first bit goes out now, the rest stays in shreg.
            if (pop) begin
                data_mod_d = LSB_FIRST ? head[0] : head[7];
                shreg_d    = LSB_FIRST ? {1'b0, head[7:1]} : {head[6:0], 1'b0};
                strobe_d   = 1'b1;
                sym_cnt_d  = '0;
                bit_cnt_d  = '0;
                rd_ptr_d   = rd_ptr_q + PW'(1);
            end

            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end

            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shreg_q    <= '0;
            sym_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_mod_q <= 1'b0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            shreg_q    <= shreg_d;
            sym_cnt_q  <= sym_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_mod_q <= data_mod_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= byte_data;
        end
    end
endmodule

// File: tb/tb_adpll_tx_serializer.sv
module tb_adpll_tx_serializer;
    localparam int SYM = 32;
    localparam int LW  = 3;

    logic          clk = 1'b0;
    logic          rst_n, en, channel_lock, byte_valid;
    logic [1:0]    adpll_mode;
    logic [7:0]    byte_data;
    logic          byte_ready, data_mod, sym_strobe, busy, underrun;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    adpll_tx_serializer #(.SYM_CYCLES(SYM), .FIFO_DEPTH(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .adpll_mode(adpll_mode),
        .channel_lock(channel_lock), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .data_mod(data_mod), .sym_strobe(sym_strobe),
        .busy(busy), .underrun(underrun), .fifo_level(fifo_level)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: accepted bytes and the cycle in which each handshake happened.
    logic [7:0] exp_q[$];
    int         pc_q[$];
    int         flush_at = -1;
    int         rdy_from = 0;

    // Monitor state (reference view of the bit stream).
    bit         in_byte = 0;
    int         bit_idx = 0;
    logic [7:0] cur = 8'h00;
    int         mpc = 0;
    int         last_strobe = 0;
    int         start_cyc = 0;
    int         last_ur = 0;
    int         n_ur = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Bit i of the transmitted sequence for a byte, LSB first.
    function automatic int tx_bit(input logic [7:0] b, input int i);
        return int'(b[i]);
    endfunction

    always @(negedge clk) begin
        if (cyc == flush_at) begin
            exp_q.delete();
            pc_q.delete();
            in_byte = 0;
            bit_idx = 0;
        end else begin
            if (sym_strobe && underrun) check("strobe_with_underrun", 1, 0);
            if (sym_strobe) begin
                if (in_byte) begin
                    check("sym_period", cyc - last_strobe, SYM);
                    if (bit_idx == 7) begin
                        if (exp_q.size() == 0) begin
                            check("b2b_byte_available", 0, 1);
                            in_byte = 0;
                        end else begin
                            cur = exp_q.pop_front();
                            mpc = pc_q.pop_front();
                            check("b2b_push_age", int'(mpc <= cyc - 2), 1);
                            bit_idx = 0;
                        end
                    end else begin
                        bit_idx++;
                    end
                end else begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        mpc = pc_q.pop_front();
                        check("start_latency", cyc, (mpc + 2 > rdy_from + 1) ? mpc + 2 : rdy_from + 1);
                        in_byte = 1;
                        bit_idx = 0;
                        start_cyc = cyc;
                    end
                end
                if (in_byte) check("data_bit", int'(data_mod), tx_bit(cur, bit_idx));
                last_strobe = cyc;
            end else if (in_byte) begin
                if (underrun) begin
                    int stale = 0;
                    check("underrun_bit", bit_idx, 7);
                    check("underrun_timing", cyc - last_strobe, SYM);
                    foreach (pc_q[i]) if (pc_q[i] <= cyc - 2) stale++;
                    check("underrun_fifo_empty", stale, 0);
                    in_byte = 0;
                    rdy_from = cyc;
                    last_ur = cyc;
                    n_ur++;
                end else if (cyc - last_strobe >= SYM) begin
                    check("strobe_or_underrun_due", cyc - last_strobe, SYM - 1);
                    in_byte = 0;
                end else begin
                    check("data_hold", int'(data_mod), tx_bit(cur, bit_idx));
                end
            end else if (underrun) begin
                check("spurious_underrun", 1, 0);
            end
            if (!in_byte) check("idle_data_mod", int'(data_mod), 0);
            check("busy", int'(busy), int'(in_byte));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_byte(input logic [7:0] b, input int max_wait);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < max_wait && !ok; i++) begin
            if (byte_ready) begin
                ok = 1;
                exp_q.push_back(b);
                pc_q.push_back(cyc);
            end
            step();
        end
        byte_valid = 1'b0;
        check("push_accepted", int'(ok), 1);
    endtask

    task automatic arm();
        en = 1'b1;
        adpll_mode = 2'd3;
        channel_lock = 1'b1;
        rdy_from = cyc + 1;
        step();
    endtask

    task automatic abort(input int kind);
        int ur0 = n_ur;
        if (kind == 0) channel_lock = 1'b0;
        else if (kind == 1) adpll_mode = 2'd2;
        else en = 1'b0;
        flush_at = cyc + 1;
        step();
        check("abort_data_mod", int'(data_mod), 0);
        check("abort_level", int'(fifo_level), 0);
        check("abort_ready", int'(byte_ready), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_underrun", int'(underrun), 0);
        step();
        check("abort_no_underrun", n_ur - ur0, 0);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_byte) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", int'(exp_q.size() == 0 && !in_byte), 1);
    endtask

    task automatic wait_bit(input int idx, input int budget);
        int n = 0;
        while (!(in_byte && bit_idx == idx) && n < budget) begin
            step();
            n++;
        end
        check("reached_bit", int'(in_byte && bit_idx == idx), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ur0;
        int n;
        // 1: reset with stimulus active, then not-armed combinations.
        rst_n = 1'b0; en = 1'b1; adpll_mode = 2'd3; channel_lock = 1'b1;
        byte_valid = 1'b1; byte_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outputs", int'({byte_ready, data_mod, sym_strobe, busy, underrun, fifo_level}), 0);
        end
        rst_n = 1'b1; adpll_mode = 2'd2;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ready_mode_rx", int'(byte_ready), 0);
        end
        adpll_mode = 2'd3; channel_lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ready_unlocked", int'(byte_ready), 0);
        end
        check("no_push_when_unarmed", int'(fifo_level), 0);
        byte_valid = 1'b0;

        // 2: single byte 0xA5.
        arm();
        check("ready_after_arm", int'(byte_ready), 1);
        ur0 = n_ur;
        push_byte(8'hA5, 4);
        wait_drain(600);
        check("t2_underruns", n_ur - ur0, 1);
        check("t2_byte_span", last_ur - start_cyc, 8 * SYM);

        // 3: four bytes back to back, one underrun at the end.
        ur0 = n_ur;
        push_byte(8'h00, 4);
        push_byte(8'hFF, 4);
        push_byte(8'h0F, 4);
        push_byte(8'hF0, 4);
        wait_drain(1500);
        check("t3_underruns", n_ur - ur0, 1);

        // 4: fill the FIFO behind a shifting byte; the next push is dropped.
        push_byte(8'h11, 4);
        push_byte(8'h22, 4);
        push_byte(8'h33, 4);
        push_byte(8'h44, 4);
        push_byte(8'h55, 4);
        check("t4_level_full", int'(fifo_level), 4);
        check("t4_ready_full", int'(byte_ready), 0);
        byte_valid = 1'b1; byte_data = 8'h66;
        step();
        byte_valid = 1'b0;
        check("t4_level_after_drop", int'(fifo_level), 4);
        n = 0;
        while (fifo_level == 3'd4 && n < 400) begin
            step();
            n++;
        end
        check("t4_level_after_pop", int'(fifo_level), 3);
        check("t4_ready_after_pop", int'(byte_ready), 1);
        wait_drain(2000);

        // 5: lose lock during bit 3 with two bytes queued.
        push_byte(8'hA1, 4);
        push_byte(8'hB2, 4);
        push_byte(8'hC3, 4);
        wait_bit(3, 300);
        repeat ($urandom_range(0, 20)) step();
        check("t5_queued", int'(fifo_level), 2);
        abort(0);
        arm();

        // 6: mode change mid-symbol, re-arm and send 0x01.
        push_byte(8'h3C, 4);
        wait_bit(2, 300);
        repeat ($urandom_range(1, 25)) step();
        abort(1);
        arm();
        ur0 = n_ur;
        push_byte(8'h01, 4);
        wait_drain(600);
        check("t6_underruns", n_ur - ur0, 1);

        // Randomised traffic with random gaps and one enable drop.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 300)) step();
            if (i == 12) begin
                abort(2);
                arm();
            end
            push_byte(8'($urandom_range(0, 255)), 2000);
        end
        wait_drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
